rpc2_ctrl_axi_rw_arbiter: RTL and testbench
===========================================

Name: rpc2_ctrl_axi_rw_arbiter

Overview:
Arbitrates between pending AXI read and write command requests in the AXI clock domain and forwards one command at a time to the RPC2 controller command path.
Contention is weighted by the synchronized transaction-allocation fields reg_rd_trans_alloc / reg_wr_trans_alloc, which set how many consecutive grants a direction keeps while the other direction waits.
It consumes the 2-flop-synchronized TAR allocation values and sits between the AXI slave command capture and the RPC2 transaction issue logic.

Parameters:
CMD_W, 48, width of command payload (address, length, id, burst attributes) per request

Ports:
AXIm_ACLK  input  1  AXI clock
AXIm_ARESETN  input  1  asynchronous active-low reset
reg_rd_trans_alloc  input  2  synchronized read allocation; read gets alloc+1 consecutive grants under contention
reg_wr_trans_alloc  input  2  synchronized write allocation; write gets alloc+1 consecutive grants under contention
rd_req_valid  input  1  read command pending
rd_req_cmd  input  CMD_W  read command payload
rd_req_ready  output  1  read command accepted this cycle
wr_req_valid  input  1  write command pending
wr_req_cmd  input  CMD_W  write command payload
wr_req_ready  output  1  write command accepted this cycle
cmd_valid  output  1  registered command available downstream
cmd_write  output  1  1 = write command, 0 = read command
cmd_payload  output  CMD_W  registered command payload
cmd_ready  input  1  downstream accepts command

Behaviour:
- Reset is AXIm_ARESETN, asynchronous, active-low; clock is AXIm_ACLK.
- Reset values: cmd_valid=0, cmd_write=0, cmd_payload=0, owner=RD_OWN, grant_cnt=0.
- rd_req_ready and wr_req_ready are forced to 0 while AXIm_ARESETN is low.
- Output stage is a single register.
  - load_en = ~cmd_valid | cmd_ready.
  - When cmd_valid=1 and cmd_ready=0, cmd_write and cmd_payload hold stable.
- Request handshake is valid/ready per AXI rules.
  - Requesters hold valid and payload stable until ready.
  - ready is combinational: rd_req_ready = load_en & grant_rd; wr_req_ready = load_en & grant_wr. At most one is high in any cycle.
  - On acceptance, the output register loads the granted payload and direction, and cmd_valid=1 the next cycle (1-cycle latency).
- When load_en=1 and no request is accepted, cmd_valid clears to 0 on a cmd_ready handshake.
- Ownership FSM states: RD_OWN, WR_OWN. grant_cnt is 3 bits and saturates at 4; it counts consecutive grants issued to the owner.
- Grant selection, evaluated only when load_en=1:
  - Only rd_req_valid: grant read.
  - Only wr_req_valid: grant write.
  - Both valid and owner=RD_OWN: grant read if grant_cnt < reg_rd_trans_alloc+1, else grant write.
  - Both valid and owner=WR_OWN: grant write if grant_cnt < reg_wr_trans_alloc+1, else grant read.
  - Neither valid: no grant; owner and grant_cnt unchanged.
- On a grant to the owner direction: grant_cnt increments (saturating).
- On a grant to the other direction: owner switches to that direction and grant_cnt is set to 1.
- Uncontended grants also count. After a long read-only stream with owner=RD_OWN, the first contention switches to write immediately once grant_cnt exceeds the read allocation.
- Allocation inputs are sampled combinationally at each decision. A change takes effect at the next decision. If the allocation is lowered below grant_cnt, the next contention switches direction.
- Reset mid-operation clears any held command: cmd_valid drops immediately on reset assertion. Requests accepted before reset are not replayed.

Test Plan:
1. Reset asserted with both valids high -> both readies 0; cmd_valid=0 and cmd_payload=0 through reset. After release with cmd_ready=1, read granted first (owner=RD_OWN, cnt=0).
2. rd_req_valid only, 5 requests back-to-back, cmd_ready=1 -> 5 read commands, one per cycle, 1-cycle latency; wr_req_ready stays 0.
3. Both valid continuously, rta=0, wta=0, cmd_ready=1 -> output direction sequence R,W,R,W,R,W.
4. Both valid continuously, rta=2, wta=0 -> sequence R,R,R,W,R,R,R,W.
5. cmd_ready=0 for 4 cycles with a command held -> cmd_payload/cmd_write stable, both req_ready=0. cmd_ready=1 -> next grant issued in the same cycle.
6. rta changed 3->0 after 2 consecutive read grants while write is pending -> next grant is write. Reset pulse mid-stream -> cmd_valid=0 and owner=RD_OWN after release.

Source files
------------

// File: rtl/rpc2_ctrl_axi_rw_arbiter.sv
// rpc2_ctrl_axi_rw_arbiter
//   Picks one pending AXI command per cycle, either a read or a write, and
//   forwards it through a single output register to the RPC2 command path.
//   When both directions are pending, the owner keeps the grant for
//   alloc+1 consecutive grants before the other direction gets a turn.
//
// Ports
//   AXIm_ACLK, AXIm_ARESETN       clock, asynchronous active-low reset
//   reg_rd/wr_trans_alloc         synchronized per-direction allocation
//   rd_req_*, wr_req_*            valid/ready request channels (ready is combinational)
//   cmd_valid/cmd_write/
//   cmd_payload/cmd_ready         registered downstream command channel

module rpc2_ctrl_axi_rw_arbiter #(
    parameter int CMD_W = 48
) (
    input  logic             AXIm_ACLK,
    input  logic             AXIm_ARESETN,
    input  logic [1:0]       reg_rd_trans_alloc,
    input  logic [1:0]       reg_wr_trans_alloc,
    input  logic             rd_req_valid,
    input  logic [CMD_W-1:0] rd_req_cmd,
    output logic             rd_req_ready,
    input  logic             wr_req_valid,
    input  logic [CMD_W-1:0] wr_req_cmd,
    output logic             wr_req_ready,
    output logic             cmd_valid,
    output logic             cmd_write,
    output logic [CMD_W-1:0] cmd_payload,
    input  logic             cmd_ready
);

    typedef enum logic {
        RD_OWN = 1'b0,
        WR_OWN = 1'b1
    } owner_t;

    localparam logic [2:0] CNT_MAX = 3'd4;

    owner_t           owner_q, owner_d;
    logic [2:0]       grant_cnt_q, grant_cnt_d;
    logic             cmd_valid_q;
    logic             cmd_write_q;
    logic [CMD_W-1:0] cmd_payload_q;

    logic             load_en;
    logic [2:0]       rd_lim;
    logic [2:0]       wr_lim;
    logic             pick_rd;
    logic             grant_rd;
    logic             grant_wr;

    assign load_en = ~cmd_valid_q | cmd_ready;
    assign rd_lim  = {1'b0, reg_rd_trans_alloc} + 3'd1;
    assign wr_lim  = {1'b0, reg_wr_trans_alloc} + 3'd1;

    // Under contention the owner keeps the grant while its count is below
    // its limit; otherwise the other direction wins.
    always_comb begin
        pick_rd = 1'b0;
        if (rd_req_valid) begin
            if (!wr_req_valid) begin
                pick_rd = 1'b1;
            end else if (owner_q == RD_OWN) begin
                pick_rd = (grant_cnt_q < rd_lim);
            end else begin
                pick_rd = ~(grant_cnt_q < wr_lim);
            end
        end
    end

    assign grant_rd = load_en & pick_rd;
    assign grant_wr = load_en & wr_req_valid & ~pick_rd;

    // Readies are gated by reset so nothing is accepted while in reset.
    assign rd_req_ready = grant_rd & AXIm_ARESETN;
    assign wr_req_ready = grant_wr & AXIm_ARESETN;

    // Ownership FSM: state register
    always_ff @(posedge AXIm_ACLK or negedge AXIm_ARESETN) begin
        if (!AXIm_ARESETN) begin
            owner_q     <= RD_OWN;
            grant_cnt_q <= '0;
        end else begin
            owner_q     <= owner_d;
            grant_cnt_q <= grant_cnt_d;
        end
    end

    // Ownership FSM: next state
    always_comb begin
        owner_d     = owner_q;
        grant_cnt_d = grant_cnt_q;
        if (grant_rd) begin
            if (owner_q == RD_OWN) begin
                grant_cnt_d = (grant_cnt_q >= CNT_MAX) ? CNT_MAX : grant_cnt_q + 3'd1;
            end else begin
                owner_d     = RD_OWN;
                grant_cnt_d = 3'd1;
            end
        end else if (grant_wr) begin
            if (owner_q == WR_OWN) begin
                grant_cnt_d = (grant_cnt_q >= CNT_MAX) ? CNT_MAX : grant_cnt_q + 3'd1;
            end else begin
                owner_d     = WR_OWN;
                grant_cnt_d = 3'd1;
            end
        end
    end

    // Output register: loads on acceptance, clears when drained with no new grant
    always_ff @(posedge AXIm_ACLK or negedge AXIm_ARESETN) begin
        if (!AXIm_ARESETN) begin
            cmd_valid_q   <= 1'b0;
            cmd_write_q   <= 1'b0;
            cmd_payload_q <= '0;
        end else if (load_en) begin
            cmd_valid_q <= grant_rd | grant_wr;
            if (grant_rd) begin
                cmd_write_q   <= 1'b0;
                cmd_payload_q <= rd_req_cmd;
            end else if (grant_wr) begin
                cmd_write_q   <= 1'b1;
                cmd_payload_q <= wr_req_cmd;
            end
        end
    end

    assign cmd_valid   = cmd_valid_q;
    assign cmd_write   = cmd_write_q;
    assign cmd_payload = cmd_payload_q;

endmodule

// File: tb/tb_rpc2_ctrl_axi_rw_arbiter.sv
// tb_rpc2_ctrl_axi_rw_arbiter
//   Cycle-level reference model of the arbiter predicts readies and the
//   accepted commands; predicted commands go into a scoreboard queue and are
//   compared against the DUT output register at each downstream handshake.

module tb_rpc2_ctrl_axi_rw_arbiter;

    localparam int CMD_W = 48;

    logic             clk;
    logic             rstn;
    logic [1:0]       rta, wta;
    logic             rd_req_valid, wr_req_valid;
    logic [CMD_W-1:0] rd_req_cmd, wr_req_cmd;
    logic             rd_req_ready, wr_req_ready;
    logic             cmd_valid, cmd_write, cmd_ready;
    logic [CMD_W-1:0] cmd_payload;

    rpc2_ctrl_axi_rw_arbiter #(.CMD_W(CMD_W)) dut (
        .AXIm_ACLK          (clk),
        .AXIm_ARESETN       (rstn),
        .reg_rd_trans_alloc (rta),
        .reg_wr_trans_alloc (wta),
        .rd_req_valid       (rd_req_valid),
        .rd_req_cmd         (rd_req_cmd),
        .rd_req_ready       (rd_req_ready),
        .wr_req_valid       (wr_req_valid),
        .wr_req_cmd         (wr_req_cmd),
        .wr_req_ready       (wr_req_ready),
        .cmd_valid          (cmd_valid),
        .cmd_write          (cmd_write),
        .cmd_payload        (cmd_payload),
        .cmd_ready          (cmd_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Reference model state
    bit             m_own_wr;
    int unsigned    m_cnt;
    bit             m_valid;
    logic [CMD_W:0] sb[$];

    // Sources
    int unsigned rd_left, wr_left;
    logic [31:0] rd_seq, wr_seq;

    // Direction capture for sequence checks
    bit          cap_on;
    int unsigned cap_n;
    logic [7:0]  seq;

    task automatic drive();
        rd_req_valid = (rd_left > 0);
        wr_req_valid = (wr_left > 0);
        rd_req_cmd   = {16'hA5A5, rd_seq};
        wr_req_cmd   = {16'h5B5B, wr_seq};
    endtask

    // One clock cycle: inputs applied at the negedge, checked 1 ns later,
    // model stepped, then wait for the next negedge.
    task automatic cycle();
        bit             le, pick_rd, g_rd, g_wr;
        logic [CMD_W:0] e;
        drive();
        #1;
        le = !m_valid || cmd_ready;
        pick_rd = 1'b0;
        if (rd_req_valid) begin
            if (!wr_req_valid) pick_rd = 1'b1;
            else if (!m_own_wr) pick_rd = (m_cnt < int'(rta) + 1);
            else pick_rd = !(m_cnt < int'(wta) + 1);
        end
        g_rd = le && pick_rd;
        g_wr = le && wr_req_valid && !pick_rd;
        check("rd_ready", 64'(rd_req_ready), 64'(g_rd));
        check("wr_ready", 64'(wr_req_ready), 64'(g_wr));
        check("cmd_valid", 64'(cmd_valid), 64'(m_valid));
        if (m_valid) begin
            if (sb.size() == 0) begin
                check("sb_underflow", 64'(1), 64'(0));
            end else begin
                e = sb[0];
                check("cmd_write", 64'(cmd_write), 64'(e[CMD_W]));
                check("cmd_payload", 64'(cmd_payload), 64'(e[CMD_W-1:0]));
                if (cmd_ready) begin
                    void'(sb.pop_front());
                    if (cap_on && cap_n < 8) begin
                        seq[cap_n] = cmd_write;
                        cap_n++;
                    end
                end
            end
        end
        if (le) begin
            m_valid = g_rd || g_wr;
            if (g_rd) sb.push_back({1'b0, rd_req_cmd});
            if (g_wr) sb.push_back({1'b1, wr_req_cmd});
        end
        if (g_rd) begin
            if (!m_own_wr) m_cnt = (m_cnt >= 4) ? 4 : m_cnt + 1;
            else begin m_own_wr = 1'b0; m_cnt = 1; end
            rd_seq++;
            rd_left--;
        end else if (g_wr) begin
            if (m_own_wr) m_cnt = (m_cnt >= 4) ? 4 : m_cnt + 1;
            else begin m_own_wr = 1'b1; m_cnt = 1; end
            wr_seq++;
            wr_left--;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        drive();
        rstn = 1'b0;
        #1;
        check("rst_rd_ready", 64'(rd_req_ready), 64'(0));
        check("rst_wr_ready", 64'(wr_req_ready), 64'(0));
        check("rst_cmd_valid", 64'(cmd_valid), 64'(0));
        check("rst_cmd_payload", 64'(cmd_payload), 64'(0));
        check("rst_cmd_write", 64'(cmd_write), 64'(0));
        m_own_wr = 1'b0;
        m_cnt    = 0;
        m_valid  = 1'b0;
        sb.delete();
        repeat (2) @(negedge clk);
        check("rst_hold_valid", 64'(cmd_valid), 64'(0));
        rstn = 1'b1;
    endtask

    initial begin
        rstn = 1'b0; rta = 2'd0; wta = 2'd0; cmd_ready = 1'b1;
        rd_left = 0; wr_left = 0; rd_seq = 32'h0; wr_seq = 32'h1000;
        cap_on = 1'b0; cap_n = 0; seq = '0;
        m_own_wr = 1'b0; m_cnt = 0; m_valid = 1'b0;
        drive();
        @(negedge clk);

        // 1: reset with both valid pending; read wins first after release
        rd_left = 1; wr_left = 1;
        do_reset();
        drive();
        #1;
        check("t1_first_rd", 64'(rd_req_ready), 64'(1));
        check("t1_first_wr", 64'(wr_req_ready), 64'(0));
        repeat (4) cycle();

        // 2: read-only stream of 5
        rd_left = 5; wr_left = 0;
        repeat (8) cycle();

        // 3: contention, rta=0 wta=0
        rta = 2'd0; wta = 2'd0; rd_left = 100; wr_left = 100;
        do_reset();
        cap_on = 1'b1; cap_n = 0; seq = '0;
        repeat (7) cycle();
        cap_on = 1'b0;
        check("t3_seq_len", 64'(cap_n), 64'(6));
        check("t3_seq", 64'(seq[5:0]), 64'(6'b101010));

        // 4: contention, rta=2 wta=0
        rta = 2'd2; wta = 2'd0;
        do_reset();
        cap_on = 1'b1; cap_n = 0; seq = '0;
        repeat (9) cycle();
        cap_on = 1'b0;
        check("t4_seq_len", 64'(cap_n), 64'(8));
        check("t4_seq", 64'(seq), 64'(8'b10001000));

        // 5: downstream stall for 4 cycles with a command held
        cmd_ready = 1'b0;
        repeat (4) cycle();
        cmd_ready = 1'b1;
        repeat (3) cycle();

        // 6: allocation lowered below grant count while write is pending
        rta = 2'd3; rd_left = 0; wr_left = 0;
        do_reset();
        rd_left = 2;
        repeat (2) cycle();
        rta = 2'd0; rd_left = 100; wr_left = 100;
        drive();
        #1;
        check("t6_switch_wr", 64'(wr_req_ready), 64'(1));
        check("t6_switch_rd", 64'(rd_req_ready), 64'(0));
        repeat (4) cycle();

        // 6b: reset pulse mid-stream; held command is dropped, owner back to read
        check("t6_pre_valid", 64'(cmd_valid), 64'(1));
        rta = 2'd0; wta = 2'd0;
        do_reset();
        drive();
        #1;
        check("t6_post_rd", 64'(rd_req_ready), 64'(1));
        check("t6_post_wr", 64'(wr_req_ready), 64'(0));
        repeat (5) cycle();

        // Drain
        rd_left = 0; wr_left = 0;
        repeat (4) cycle();
        check("sb_empty", 64'(sb.size()), 64'(0));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
